// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, issues one icache request at a time,
// predecodes the returned word and buffers it in the IQ.
// Optional: define STATIC_JAL_EN to predict JAL statically.
module fetch_unit #(
   parameter int          IQ_DEPTH_LOG = 4,
   parameter logic [31:0] RESET_PC     = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   output logic        icache_valid,
   output logic [31:0] icache_addr,
   input  logic        icache_done,
   input  logic [31:0] icache_inst,
   output logic [31:0] bht_index,
   input  logic        bht_taken,
   output logic        iq_valid,
   output logic [31:0] iq_inst,
   output logic [31:0] iq_pc,
   output logic        iq_pred_taken,
   input  logic        iq_pop,
   input  logic        rob_clear,
   input  logic [31:0] rob_new_pc
);

   localparam int DEPTH = 1 << IQ_DEPTH_LOG;
   localparam int PW    = IQ_DEPTH_LOG;

   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [PW:0]   CNT_ONE = 1;

   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DISC
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          iv_q, iv_d;
   logic [31:0]   addr_q, addr_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW:0]   cnt_q, cnt_d;

   logic [31:0] qinst_q [DEPTH];
   logic [31:0] qpc_q   [DEPTH];
   logic        qpred_q [DEPTH];

   logic        enq;
   logic        pop;
   logic [6:0]  opcode;
   logic [31:0] b_imm;
   logic [31:0] next_pc;
   logic        pred;
`ifdef STATIC_JAL_EN
   logic [31:0] j_imm;
`endif

   assign icache_valid  = iv_q;
   assign icache_addr   = addr_q;
   assign bht_index     = {20'b0, pc_q[13:2]};
   assign iq_valid      = (cnt_q != '0);
   assign iq_inst       = qinst_q[head_q];
   assign iq_pc         = qpc_q[head_q];
   assign iq_pred_taken = qpred_q[head_q];

   // Predecode the returned word into a predicted next PC.
   always_comb begin
      opcode  = icache_inst[6:0];
      b_imm   = {{20{icache_inst[31]}}, icache_inst[7],
                 icache_inst[30:25], icache_inst[11:8], 1'b0};
      pred    = 1'b0;
      next_pc = pc_q + 32'd4;
`ifdef STATIC_JAL_EN
      j_imm   = {{12{icache_inst[31]}}, icache_inst[19:12],
                 icache_inst[20], icache_inst[30:21], 1'b0};
`endif
      if (opcode == OP_BR && bht_taken) begin
         pred    = 1'b1;
         next_pc = pc_q + b_imm;
      end
`ifdef STATIC_JAL_EN
      if (opcode == OP_JAL) begin
         pred    = 1'b1;
         next_pc = pc_q + j_imm;
      end
`endif
   end

   // Next-state: request FSM, PC update, queue pointers.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      iv_d    = iv_q;
      addr_d  = addr_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      enq     = 1'b0;
      pop     = 1'b0;
      if (rdy) begin
         if (rob_clear) begin
            pc_d   = rob_new_pc;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            unique case (state_q)
               S_IDLE: state_d = S_IDLE;
               S_WAIT, S_DISC: begin
                  if (icache_done) begin
                     state_d = S_IDLE;
                     iv_d    = 1'b0;
                  end else begin
                     state_d = S_DISC;
                  end
               end
               default: state_d = S_IDLE;
            endcase
         end else begin
            pop = iq_pop && (cnt_q != '0);
            unique case (state_q)
               S_IDLE: begin
                  if (!cnt_q[PW]) begin
                     addr_d  = pc_q;
                     iv_d    = 1'b1;
                     state_d = S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (icache_done) begin
                     enq     = 1'b1;
                     pc_d    = next_pc;
                     iv_d    = 1'b0;
                     state_d = S_IDLE;
                  end
               end
               S_DISC: begin
                  if (icache_done) begin
                     iv_d    = 1'b0;
                     state_d = S_IDLE;
                  end
               end
               default: state_d = S_IDLE;
            endcase
            if (pop) head_d = head_q + PTR_ONE;
            if (enq) tail_d = tail_q + PTR_ONE;
            unique case ({enq, pop})
               2'b10:   cnt_d = cnt_q + CNT_ONE;
               2'b01:   cnt_d = cnt_q - CNT_ONE;
               default: cnt_d = cnt_q;
            endcase
         end
      end
   end

   // Control and pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         iv_q    <= 1'b0;
         addr_q  <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         iv_q    <= iv_d;
         addr_q  <= addr_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
      end
   end

   // Queue storage; written at the tail on enqueue.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            qinst_q[i] <= '0;
            qpc_q[i]   <= '0;
            qpred_q[i] <= 1'b0;
         end
      end else if (enq) begin
         qinst_q[tail_q] <= icache_inst;
         qpc_q[tail_q]   <= pc_q;
         qpred_q[tail_q] <= pred;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a
// transaction-level model of the fetch stage and its queue.
module tb_fetch_unit;

   localparam logic [31:0] RPC = 32'h0;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        icache_valid;
   logic [31:0] icache_addr;
   logic        icache_done;
   logic [31:0] icache_inst;
   logic [31:0] bht_index;
   logic        bht_taken;
   logic        iq_valid;
   logic [31:0] iq_inst, iq_pc;
   logic        iq_pred_taken;
   logic        iq_pop;
   logic        rob_clear;
   logic [31:0] rob_new_pc;

   fetch_unit #(.IQ_DEPTH_LOG(4), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .icache_valid(icache_valid), .icache_addr(icache_addr),
      .icache_done(icache_done), .icache_inst(icache_inst),
      .bht_index(bht_index), .bht_taken(bht_taken),
      .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
      .iq_pred_taken(iq_pred_taken), .iq_pop(iq_pop),
      .rob_clear(rob_clear), .rob_new_pc(rob_new_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_disc;
   int          tests = 0;
   int          fails = 0;
   int          idle_run = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic predict(input logic [31:0] inst, input logic [31:0] pc,
                          input logic bt, output logic [31:0] nxt,
                          output logic p);
      int imm;
      p   = 1'b0;
      nxt = pc + 32'd4;
      if (inst[6:0] == 7'h63 && bt) begin
         imm = int'($signed({inst[31], inst[7], inst[30:25],
                             inst[11:8]})) * 2;
         nxt = pc + imm;
         p   = 1'b1;
      end
`ifdef STATIC_JAL_EN
      if (inst[6:0] == 7'h6F) begin
         imm = int'($signed({inst[31], inst[19:12], inst[20],
                             inst[30:21]})) * 2;
         nxt = pc + imm;
         p   = 1'b1;
      end
`endif
   endtask

   task automatic compare();
      chk("iq_valid", iq_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("iq_inst", iq_inst, mq[0].inst);
         chk("iq_pc", iq_pc, mq[0].pc);
         chk("iq_pred", iq_pred_taken, mq[0].pred);
      end
      chk("bht_index", bht_index, {20'b0, m_pc[13:2]});
      if (icache_valid && !m_disc)
         chk("icache_addr", icache_addr, m_pc);
      if (mq.size() == 16)
         chk("full_no_req", icache_valid, 1'b0);
   endtask

   task automatic step();
      logic        v, p;
      logic [31:0] nx;
      bit          act;
      v   = icache_valid;
      act = !rst && rdy && !rob_clear;
      if (rst) begin
         mq.delete();
         m_pc   = RPC;
         m_disc = 0;
      end else if (rdy) begin
         if (rob_clear) begin
            mq.delete();
            m_pc   = rob_new_pc;
            m_disc = v && !icache_done;
         end else begin
            if (iq_pop && mq.size() > 0) void'(mq.pop_front());
            if (icache_done && v) begin
               if (m_disc) begin
                  m_disc = 0;
               end else begin
                  predict(icache_inst, m_pc, bht_taken, nx, p);
                  mq.push_back('{icache_inst, m_pc, p});
                  m_pc = nx;
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      compare();
      if (act && !icache_valid && mq.size() < 16) idle_run++;
      else idle_run = 0;
      chk("no_stall", idle_run > 2, 1'b0);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!icache_valid && n < 10) begin
         step();
         n++;
      end
      chk("req_timeout", icache_valid, 1'b1);
   endtask

   task automatic deliver(input logic [31:0] inst, input logic bt);
      wait_req();
      icache_done = 1'b1;
      icache_inst = inst;
      bht_taken   = bt;
      step();
      icache_done = 1'b0;
      bht_taken   = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] a);
      rob_clear  = 1'b1;
      rob_new_pc = a;
      step();
      rob_clear  = 1'b0;
      if (icache_valid) begin
         icache_done = 1'b1;
         step();
         icache_done = 1'b0;
      end
      wait_req();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 2))
         0: w[6:0] = 7'h63;
         1: w[6:0] = 7'h6F;
         default: if (w[6:0] == 7'h63 || w[6:0] == 7'h6F) w[6:0] = 7'h13;
      endcase
      return w;
   endfunction

   initial begin
      logic [31:0] s_addr, s_inst, s_pc;
      logic        s_v;
      bit          armed;
      int          lat;
      rst = 1'b1; rdy = 1'b1; icache_done = 1'b0; icache_inst = '0;
      bht_taken = 1'b0; iq_pop = 1'b0; rob_clear = 1'b0;
      rob_new_pc = '0;
      m_pc = RPC; m_disc = 0;
      step();
      step();
      chk("rst_icache_valid", icache_valid, 1'b0);
      chk("rst_icache_addr", icache_addr, 32'h0);
      chk("rst_iq_valid", iq_valid, 1'b0);
      chk("rst_iq_inst", iq_inst, 32'h0);
      chk("rst_iq_pc", iq_pc, 32'h0);
      chk("rst_iq_pred", iq_pred_taken, 1'b0);
      rst = 1'b0;
      step();
      chk("first_req_valid", icache_valid, 1'b1);
      chk("first_req_addr", icache_addr, 32'h0);
      deliver(32'h0000_0013, 1'b0);
      chk("nop_inst", iq_inst, 32'h0000_0013);
      chk("nop_pc", iq_pc, 32'h0);
      chk("nop_pred", iq_pred_taken, 1'b0);
      wait_req();
      chk("second_addr", icache_addr, 32'h4);

      rob_clear = 1'b1; rob_new_pc = 32'h400;
      step();
      rob_clear = 1'b0;
      chk("flush_empty", iq_valid, 1'b0);
      chk("discard_valid", icache_valid, 1'b1);
      chk("discard_addr", icache_addr, 32'h4);
      step();
      step();
      icache_done = 1'b1; icache_inst = 32'h0000_0013;
      step();
      icache_done = 1'b0;
      chk("discard_dropped", iq_valid, 1'b0);
      wait_req();
      chk("redirect_addr", icache_addr, 32'h400);

      redirect(32'h100);
      chk("br_addr", icache_addr, 32'h100);
      chk("br_bht_index", bht_index, 32'h40);
      deliver(32'h0000_0463, 1'b1);
      chk("br_t_pc", iq_pc, 32'h100);
      chk("br_t_pred", iq_pred_taken, 1'b1);
      wait_req();
      chk("br_t_next", icache_addr, 32'h108);

      redirect(32'h100);
      deliver(32'h0000_0463, 1'b0);
      chk("br_nt_pred", iq_pred_taken, 1'b0);
      wait_req();
      chk("br_nt_next", icache_addr, 32'h104);

      redirect(32'h200);
      deliver(32'h0100_006F, 1'b0);
      wait_req();
`ifdef STATIC_JAL_EN
      chk("jal_pred", iq_pred_taken, 1'b1);
      chk("jal_next", icache_addr, 32'h210);
`else
      chk("jal_pred", iq_pred_taken, 1'b0);
      chk("jal_next", icache_addr, 32'h204);
`endif

      redirect(32'h0);
      for (int i = 0; i < 16; i++) deliver(32'h0000_0013, 1'b0);
      step();
      step();
      chk("full_valid_low", icache_valid, 1'b0);
      chk("full_iq_valid", iq_valid, 1'b1);
      chk("full_head_pc", iq_pc, 32'h0);
      iq_pop = 1'b1;
      step();
      iq_pop = 1'b0;
      step();
      chk("refill_req", icache_valid, 1'b1);
      chk("refill_addr", icache_addr, 32'h40);

      s_addr = icache_addr; s_v = icache_valid;
      s_inst = iq_inst; s_pc = iq_pc;
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         iq_pop = 1'b1; icache_done = 1'b1; rob_clear = 1'b1;
         rob_new_pc = 32'hDEAD_BEE0; icache_inst = 32'h0000_0463;
         step();
         chk("frz_addr", icache_addr, s_addr);
         chk("frz_valid", icache_valid, s_v);
         chk("frz_inst", iq_inst, s_inst);
         chk("frz_pc", iq_pc, s_pc);
      end
      rdy = 1'b1; iq_pop = 1'b0; icache_done = 1'b0; rob_clear = 1'b0;
      deliver(32'h0000_0013, 1'b0);
      chk("thaw_full", icache_valid, 1'b0);

      armed = 0;
      lat   = 0;
      for (int c = 0; c < 4000; c++) begin
         rdy        = ($urandom_range(0, 9) != 0);
         iq_pop     = (c < 2000) ? ($urandom_range(0, 3) == 0)
                                 : ($urandom_range(0, 3) != 0);
         rob_clear  = ($urandom_range(0, 40) == 0);
         rob_new_pc = $urandom & 32'hFFFF_FFFC;
         bht_taken  = $urandom_range(0, 1) == 1;
         icache_done = 1'b0;
         if (icache_valid && !armed) begin
            armed = 1;
            lat   = $urandom_range(0, 3);
         end
         if (armed && rdy) begin
            if (lat == 0) begin
               icache_done = 1'b1;
               icache_inst = rand_inst();
               armed       = 0;
            end else begin
               lat--;
            end
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
